// File: rtl/mul_nbit_seq.sv
// Sequential WIDTH-bit multiplier with an unsigned integer mode and a GF(2^WIDTH) mode.
// It performs one shift-add step (integer) or one xtime-xor step (GF) per clock.
// Each operation takes exactly WIDTH steps, whatever the operand values.
// Valid/ready handshakes are used on the operand side and on the result side.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for operands, in_ready_o=1
// BUSY  | WIDTH multiply steps, one per clock
// DONE  | product_o valid, held until out_ready_i
module mul_nbit_seq #(
   parameter int unsigned            WIDTH = 8,
   parameter logic [WIDTH-1:0]       POLY  = WIDTH'('h1B)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic                 mode_i,
   input  logic [WIDTH-1:0]     operand_a_i,
   input  logic [WIDTH-1:0]     operand_b_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [2*WIDTH-1:0]   product_o
);

   generate
      if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
         $fatal(1, "mul_nbit_seq: WIDTH must be in 2..32");
      end
   endgenerate

   localparam int unsigned     CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [2*WIDTH-1:0]     a_sh_q, a_sh_d;
   logic [WIDTH-1:0]       b_q, b_d;
   logic                   mode_q;
   logic [2*WIDTH-1:0]     acc_q, acc_d;
   logic [CW-1:0]          cnt_q;
   logic [WIDTH-1:0]       gf_xt;

   // State register; reset abandons any in-flight operation at once
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; the step count alone decides when BUSY ends
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (in_valid_i)       state_d = BUSY;
         BUSY: if (cnt_q == LAST)    state_d = DONE;
         DONE: if (out_ready_i)      state_d = IDLE;
         default:                    state_d = IDLE;
      endcase
   end

   // One multiply step: integer is LSB-first shift-add, GF is MSB-first Horner with xtime
   always_comb begin
      acc_d  = acc_q;
      a_sh_d = a_sh_q;
      b_d    = b_q;
      gf_xt  = {acc_q[WIDTH-2:0], 1'b0} ^ (acc_q[WIDTH-1] ? POLY : '0);
      if (mode_q) begin
         acc_d = {{WIDTH{1'b0}}, gf_xt ^ (b_q[WIDTH-1] ? a_sh_q[WIDTH-1:0] : '0)};
         b_d   = b_q << 1;
      end else begin
         if (b_q[0]) begin
            acc_d = acc_q + a_sh_q;
         end
         a_sh_d = a_sh_q << 1;
         b_d    = b_q >> 1;
      end
   end

   // Operand capture on accept, step registers while BUSY, hold otherwise
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         a_sh_q <= '0;
         b_q    <= '0;
         mode_q <= 1'b0;
         acc_q  <= '0;
         cnt_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid_i) begin
                  a_sh_q <= {{WIDTH{1'b0}}, operand_a_i};
                  b_q    <= operand_b_i;
                  mode_q <= mode_i;
                  acc_q  <= '0;
                  cnt_q  <= '0;
               end
            end
            BUSY: begin
               a_sh_q <= a_sh_d;
               b_q    <= b_d;
               acc_q  <= acc_d;
               cnt_q  <= cnt_q + CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign in_ready_o  = (state_q == IDLE);
   assign out_valid_o = (state_q == DONE);
   assign product_o   = acc_q;

endmodule

// File: tb/tb_mul_nbit_seq.sv
// Directed bench for mul_nbit_seq: an 8-bit AES-polynomial instance and a 4-bit GF(16) instance.
module tb_mul_nbit_seq;

   logic        clk = 1'b0;
   logic        rst;

   logic        in_valid8, in_ready8, mode8, out_valid8, out_ready8;
   logic [7:0]  a8, b8;
   logic [15:0] product8;

   logic        in_valid4, in_ready4, mode4, out_valid4, out_ready4;
   logic [3:0]  a4, b4;
   logic [7:0]  product4;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mul_nbit_seq #(.WIDTH(8), .POLY(8'h1B)) u_dut8 (
      .clk_i(clk), .rst_i(rst),
      .in_valid_i(in_valid8), .in_ready_o(in_ready8), .mode_i(mode8),
      .operand_a_i(a8), .operand_b_i(b8),
      .out_valid_o(out_valid8), .out_ready_i(out_ready8), .product_o(product8)
   );

   mul_nbit_seq #(.WIDTH(4), .POLY(4'h3)) u_dut4 (
      .clk_i(clk), .rst_i(rst),
      .in_valid_i(in_valid4), .in_ready_o(in_ready4), .mode_i(mode4),
      .operand_a_i(a4), .operand_b_i(b4),
      .out_valid_o(out_valid4), .out_ready_i(out_ready4), .product_o(product4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // GF(2^w) reference, LSB-first: shift a up with reduction, xor into p for each set bit of b
   function automatic logic [7:0] gf_ref(input logic [7:0] a, input logic [7:0] b,
                                          input int w, input logic [7:0] poly);
      logic [7:0] p, aa, mask;
      logic       carry;
      p    = '0;
      aa   = a;
      mask = 8'((1 << w) - 1);
      for (int i = 0; i < w; i++) begin
         if (b[i]) p = p ^ aa;
         carry = aa[w-1];
         aa    = (aa << 1) & mask;
         if (carry) aa = aa ^ poly;
      end
      return p;
   endfunction

   function automatic logic sel_valid(input bit s4);
      return s4 ? out_valid4 : out_valid8;
   endfunction

   function automatic logic [15:0] sel_prod(input bit s4);
      return s4 ? {8'h00, product4} : product8;
   endfunction

   // Full operation: accept, scramble inputs, measure latency, check result, hand it off
   task automatic run_op(input bit s4, input bit mode, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp, input string tag);
      int lat;
      @(negedge clk);
      if (s4) begin in_valid4 = 1'b1; mode4 = mode; a4 = a[3:0]; b4 = b[3:0]; end
      else    begin in_valid8 = 1'b1; mode8 = mode; a8 = a;      b8 = b;      end
      @(posedge clk);
      @(negedge clk);
      if (s4) begin in_valid4 = 1'b0; mode4 = ~mode; a4 = ~a[3:0]; b4 = ~b[3:0]; end
      else    begin in_valid8 = 1'b0; mode8 = ~mode; a8 = ~a;      b8 = ~b;      end
      lat = 0;
      while (!sel_valid(s4) && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, " latency"}, 32'(lat), s4 ? 32'd4 : 32'd8);
      chk({tag, " product"}, {16'h0, sel_prod(s4)}, {16'h0, exp});
      if (s4) out_ready4 = 1'b1; else out_ready8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (s4) out_ready4 = 1'b0; else out_ready8 = 1'b0;
      chk({tag, " valid after handoff"}, {31'h0, sel_valid(s4)}, 32'd0);
   endtask

   initial begin
      int spurious;
      int lat;
      rst = 1'b1;
      in_valid8 = 0; mode8 = 0; a8 = 0; b8 = 0; out_ready8 = 0;
      in_valid4 = 0; mode4 = 0; a4 = 0; b4 = 0; out_ready4 = 0;
      repeat (2) @(negedge clk);
      chk("reset in_ready", {31'h0, in_ready8}, 32'd1);
      chk("reset out_valid", {31'h0, out_valid8}, 32'd0);
      chk("reset product", {16'h0, product8}, 32'h0);
      rst = 1'b0;

      run_op(0, 1'b1, 8'h57, 8'h83, 16'h00C1, "gf8 57*83");
      run_op(0, 1'b1, 8'h57, 8'h13, 16'h00FE, "gf8 57*13");
      run_op(0, 1'b0, 8'hFF, 8'hFF, 16'hFE01, "int8 FF*FF");
      run_op(0, 1'b0, 8'h00, 8'hA5, 16'h0000, "int8 00*A5");
      run_op(0, 1'b0, 8'h01, 8'h01, 16'h0001, "int8 01*01");
      run_op(0, 1'b0, 8'h80, 8'h02, 16'h0100, "int8 80*02");
      run_op(0, 1'b1, 8'h80, 8'h02, 16'h001B, "gf8 80*02");

      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++)
            run_op(1, 1'b0, 8'(i), 8'(j), 16'(i * j), "int4");
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++)
            run_op(1, 1'b1, 8'(i), 8'(j), {8'h00, gf_ref(8'(i), 8'(j), 4, 8'h03)}, "gf4");
      run_op(1, 1'b1, 8'h08, 8'h02, 16'h0003, "gf4 8*2");

      // back-pressure: result held, new operands ignored
      @(negedge clk);
      in_valid8 = 1'b1; mode8 = 1'b1; a8 = 8'h57; b8 = 8'h83;
      @(posedge clk);
      @(negedge clk);
      in_valid8 = 1'b0;
      lat = 0;
      while (!out_valid8 && lat < 40) begin @(negedge clk); lat++; end
      chk("bp latency", 32'(lat), 32'd8);
      for (int k = 0; k < 5; k++) begin
         in_valid8 = (k == 1 || k == 2); mode8 = 1'b0; a8 = 8'h12; b8 = 8'h34;
         chk("bp product", {16'h0, product8}, 32'h00C1);
         chk("bp in_ready", {31'h0, in_ready8}, 32'd0);
         chk("bp out_valid", {31'h0, out_valid8}, 32'd1);
         @(negedge clk);
      end
      in_valid8 = 1'b0;
      chk("bp product end", {16'h0, product8}, 32'h00C1);
      out_ready8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready8 = 1'b0;
      chk("bp release valid", {31'h0, out_valid8}, 32'd0);
      chk("bp release ready", {31'h0, in_ready8}, 32'd1);
      run_op(0, 1'b0, 8'h03, 8'h05, 16'h000F, "post bp");

      // reset after step 3 of an operation
      @(negedge clk);
      in_valid8 = 1'b1; mode8 = 1'b1; a8 = 8'h57; b8 = 8'h83;
      @(posedge clk);
      @(negedge clk);
      in_valid8 = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("rst busy in_ready", {31'h0, in_ready8}, 32'd1);
      chk("rst busy out_valid", {31'h0, out_valid8}, 32'd0);
      chk("rst busy product", {16'h0, product8}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      spurious = 0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid8) spurious++;
      end
      chk("rst no spurious result", 32'(spurious), 32'd0);
      run_op(0, 1'b0, 8'hFF, 8'hFF, 16'hFE01, "post rst");

      // reset while a result is waiting
      @(negedge clk);
      in_valid8 = 1'b1; mode8 = 1'b0; a8 = 8'h0C; b8 = 8'h0D;
      @(posedge clk);
      @(negedge clk);
      in_valid8 = 1'b0;
      lat = 0;
      while (!out_valid8 && lat < 40) begin @(negedge clk); lat++; end
      chk("rst done product", {16'h0, product8}, 32'h009C);
      rst = 1'b1;
      #1;
      chk("rst done out_valid", {31'h0, out_valid8}, 32'd0);
      chk("rst done in_ready", {31'h0, in_ready8}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      run_op(0, 1'b1, 8'h02, 8'h87, 16'h0015, "post rst done");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mul_nbit_seq.md
# mul_nbit_seq

Parametrised sequential multiplier with two modes: unsigned integer multiply and GF(2^WIDTH) polynomial multiply with modular reduction. It uses one shift-add (or xtime-xor) step per clock and valid/ready handshakes on both sides. It is the area-lean, width-generic successor to the combinational 4-bit array multiplier. It serves the AES datapath, for MixColumns/InvMixColumns coefficients and key-schedule arithmetic, and general integer products.

## Interface
Parameters:
- WIDTH, 8: operand width in bits. Legal range 2..32; other values are a fatal elaboration error.
- POLY, 8'h1B: low WIDTH bits of the GF reduction polynomial; the x^WIDTH term is implicit. The default gives the AES polynomial x^8+x^4+x^3+x+1.

Ports:
- clk_i, input, 1: single clock, rising edge.
- rst_i, input, 1: reset, asynchronous, active-high.
- in_valid_i, input, 1: operands and mode are valid.
- in_ready_o, output, 1: block can accept a new operation.
- mode_i, input, 1: 0 = unsigned integer multiply, 1 = GF(2^WIDTH) multiply.
- operand_a_i, input, WIDTH: multiplicand.
- operand_b_i, input, WIDTH: multiplier.
- out_valid_o, output, 1: product_o holds a completed result.
- out_ready_i, input, 1: consumer accepts the result.
- product_o, output, 2*WIDTH: result. In GF mode the upper WIDTH bits are 0.

## Operation
FSM states and transitions:
- IDLE: in_ready_o=1.
  - On in_valid_i=1, capture a, b and mode.
  - Clear the accumulator and the step counter.
  - Go to BUSY.
- BUSY: one step per clock, exactly WIDTH steps; in_ready_o=0.
  - Integer mode (LSB-first):
    - If b[0] is set, acc += a_sh, where a_sh is 2*WIDTH bits and a is zero-extended.
    - Then a_sh <<= 1 and b >>= 1.
    - The sum never overflows 2*WIDTH bits.
  - GF mode (MSB-first):
    - acc = xtime(acc) ^ (b[WIDTH-1] ? a : 0), then b <<= 1.
    - xtime(x) = (x<<1)[WIDTH-1:0] ^ (x[WIDTH-1] ? POLY : 0).
    - The accumulator stays WIDTH bits.
  - After step WIDTH, go to DONE.
- DONE: out_valid_o=1 and product_o holds the result, stable until out_ready_i=1.
  - On out_ready_i=1, go to IDLE.
  - in_ready_o=0 while in DONE, so in_valid_i is ignored.

Boundary conditions:
- Zero operands and operand value 1 still take the full WIDTH steps. There is no early termination, and latency does not depend on the data.
- Inputs are sampled only on the accept edge. Changes to operands or mode during BUSY or DONE have no effect.
- Reset in any state returns the block to IDLE immediately (asynchronously). Any in-flight result is discarded and no out_valid_o pulse is produced.
- product_o outside DONE:
  - It shows the running accumulator.
  - Only the value while out_valid_o=1 is defined.
  - The bench must not check it in other states.

## Timing
- Reset values: in_ready_o=1 (IDLE), out_valid_o=0, product_o=0, internal registers=0.
- Accept edge T is the rising edge with in_valid_i & in_ready_o.
- Steps happen on edges T+1 through T+WIDTH.
- out_valid_o goes high after edge T+WIDTH, so latency is WIDTH clocks from accept to valid.
- Output handshake on edge U (out_valid_o & out_ready_i): out_valid_o=0 and in_ready_o=1 after U. The earliest next accept is edge U+1.
- Peak throughput is one result per WIDTH+2 clocks. The block holds one operation only; it does not pipeline.
- All outputs are registered, with no combinational path from input to output.

## Test plan
- WIDTH=8, mode=1, a=0x57, b=0x83 -> product_o=0x00C1 with out_valid_o exactly 8 clocks after accept. Also a=0x57, b=0x13 -> 0x00FE.
- WIDTH=8, mode=0, a=0xFF, b=0xFF -> 0xFE01. Also a=0x00, b=0xA5 -> 0x0000 with the same 8-clock latency.
- WIDTH=4, mode=0, exhaustive 256 pairs -> product_o equals a*b in every case (for example 15*15=0xE1). This matches the legacy 4-bit multiplier.
- WIDTH=4, POLY=4'h3, mode=1, exhaustive sweep -> matches a GF(16) reference model (for example 0x8*0x2=0x3).
- Back-pressure: hold out_ready_i=0 for 5 clocks and pulse in_valid_i with new operands meanwhile -> product_o is stable, in_ready_o=0, and the new operands are ignored. On release, IDLE follows and the next accept succeeds.
- Assert rst_i mid-BUSY (after step 3) -> out_valid_o=0 and in_ready_o=1 immediately with no clock needed. There is no spurious result, and a fresh operation afterwards completes correctly.
